assoc_data_cache: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate data cache between the CPU load/store port and the block-wide data memory.
- Successor to the fixed direct-mapped data cache. Generalised in address/data width, block size, set count and associativity; adds true-LRU replacement.
- Drop-in at the CPU side (READ/WRITE/BUSYWAIT handshake) and the memory side (MEM_* handshake) of the CPU top-level integration.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/cache_lru.sv | 65 ++++++
 rtl/assoc_data_cache.sv | 191 +++++++++++++++++++
 tb/tb_assoc_data_cache.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative data cache: FSM encoding and field-width helpers.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FETCH     = 2'd2,
    ST_UPDATE    = 2'd3
  } cache_state_e;

  // Bits needed to index n items; a single item still gets a one-bit (always zero) index.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned tag_bits(input int unsigned addr_w, input int unsigned words,
                                           input int unsigned sets);
    return addr_w - idx_bits(words) - idx_bits(sets);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age tracking per set (age 0 = most recent) and replacement victim selection.
module cache_lru
  import cache_pkg::*;
#(
  parameter int unsigned SETS = 4,
  parameter int unsigned WAYS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [idx_bits(SETS)-1:0] set_idx,
  input  logic [WAYS-1:0]           set_valid,
  input  logic                      touch,
  input  logic [idx_bits(WAYS)-1:0] touch_way,
  output logic [idx_bits(WAYS)-1:0] victim_c
);

  localparam int unsigned WAY_W = idx_bits(WAYS);

  if (WAYS == 1) begin : g_direct
    assign victim_c = '0;
  end else begin : g_lru
    localparam logic [WAY_W-1:0] OLDEST = WAY_W'(WAYS - 1);

    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] touched_age;

    assign touched_age = age_q[set_idx][touch_way];

    // Lowest-numbered invalid way first, otherwise the oldest way.
    always_comb begin
      logic found;
      victim_c = '0;
      found    = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        if (!found && !set_valid[w]) begin
          victim_c = WAY_W'(w);
          found    = 1'b1;
        end
      end
      if (!found) begin
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[set_idx][w] == OLDEST) victim_c = WAY_W'(w);
        end
      end
    end

    // '<=' rather than '<' breaks the all-zero tie left by reset, so ages become distinct as a set fills.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
        end
      end else if (touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == touch_way) begin
            age_q[set_idx][w] <= '0;
          end else if (age_q[set_idx][w] <= touched_age && age_q[set_idx][w] != OLDEST) begin
            age_q[set_idx][w] <= age_q[set_idx][w] + WAY_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/assoc_data_cache.sv
// N-way set-associative write-back, write-allocate data cache between the CPU load/store port
// and a block-wide memory; misses run IDLE -> (WRITEBACK) -> FETCH -> UPDATE -> IDLE.
module assoc_data_cache
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned SETS   = 4,
  parameter int unsigned WAYS   = 2
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              READ,
  input  logic                              WRITE,
  input  logic [ADDR_W-1:0]                 ADDRESS,
  input  logic [DATA_W-1:0]                 WRITEDATA,
  output logic [DATA_W-1:0]                 READDATA,
  output logic                              BUSYWAIT,
  output logic                              MEM_READ,
  output logic                              MEM_WRITE,
  output logic [ADDR_W-idx_bits(WORDS)-1:0] MEM_ADDRESS,
  output logic [DATA_W*WORDS-1:0]           MEM_WRITEDATA,
  input  logic [DATA_W*WORDS-1:0]           MEM_READDATA,
  input  logic                              MEM_BUSYWAIT
);

  localparam int unsigned OFF_W = idx_bits(WORDS);
  localparam int unsigned IDX_W = idx_bits(SETS);
  localparam int unsigned TAG_W = tag_bits(ADDR_W, WORDS, SETS);
  localparam int unsigned WAY_W = idx_bits(WAYS);
  localparam int unsigned BLK_W = DATA_W * WORDS;
  localparam int unsigned BA_W  = ADDR_W - OFF_W;

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             req;

  assign off = ADDRESS[OFF_W-1:0];
  assign idx = ADDRESS[OFF_W +: IDX_W];
  assign tag = ADDRESS[ADDR_W-1 -: TAG_W];
  assign req = READ | WRITE;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [BLK_W-1:0] data_q  [SETS][WAYS];

  cache_state_e     state_q, state_d;
  logic [WAY_W-1:0] vic_q, victim, hit_way, touch_way;
  logic             hit, idle_hit, write_hit, touch;
  logic [BLK_W-1:0] hit_blk;
  logic [DATA_W-1:0] hit_word;
  logic             mem_read_d, mem_write_d;
  logic [BA_W-1:0]  mem_addr_d;
  logic [BLK_W-1:0] mem_wdata_d;

  // Tag compare across all ways of the indexed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_blk = data_q[idx][hit_way];

  always_comb begin
    hit_word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (off == OFF_W'(i)) hit_word = hit_blk[i*DATA_W +: DATA_W];
    end
  end

  assign idle_hit  = (state_q == ST_IDLE) && hit;
  assign write_hit = idle_hit && WRITE;
  assign READDATA  = idle_hit ? hit_word : '0;
  assign BUSYWAIT  = RESET && req && !idle_hit;

  assign touch     = (state_q == ST_UPDATE) || (idle_hit && req);
  assign touch_way = (state_q == ST_UPDATE) ? vic_q : hit_way;

  cache_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clk       (CLK),
    .rst_n     (RESET),
    .set_idx   (idx),
    .set_valid (valid_q[idx]),
    .touch     (touch),
    .touch_way (touch_way),
    .victim_c  (victim)
  );

  // Next state and next memory-side outputs; memory outputs are held while the memory is busy.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (req && !hit) begin
          if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
            state_d     = ST_WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[idx][victim], idx};
            mem_wdata_d = data_q[idx][victim];
          end else begin
            state_d    = ST_FETCH;
            mem_read_d = 1'b1;
            mem_addr_d = {tag, idx};
          end
        end
      end
      ST_WRITEBACK: begin
        if (MEM_BUSYWAIT) begin
          mem_write_d = 1'b1;
          mem_addr_d  = MEM_ADDRESS;
          mem_wdata_d = MEM_WRITEDATA;
        end else begin
          state_d    = ST_FETCH;
          mem_read_d = 1'b1;
          mem_addr_d = {tag, idx};
        end
      end
      ST_FETCH: begin
        if (MEM_BUSYWAIT) begin
          mem_read_d = 1'b1;
          mem_addr_d = MEM_ADDRESS;
        end else begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_IDLE;
      vic_q         <= '0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
    end else begin
      state_q       <= state_d;
      MEM_READ      <= mem_read_d;
      MEM_WRITE     <= mem_write_d;
      MEM_ADDRESS   <= mem_addr_d;
      MEM_WRITEDATA <= mem_wdata_d;
      if (state_q == ST_IDLE && req && !hit) vic_q <= victim;
    end
  end

  // Line status bits are the only reset state; tags and data are qualified by valid.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else if (state_q == ST_UPDATE) begin
      valid_q[idx][vic_q] <= 1'b1;
      dirty_q[idx][vic_q] <= 1'b0;
    end else if (write_hit) begin
      dirty_q[idx][hit_way] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == ST_UPDATE) begin
      tag_q[idx][vic_q]  <= tag;
      data_q[idx][vic_q] <= MEM_READDATA;
    end else if (write_hit) begin
      for (int i = 0; i < WORDS; i++) begin
        if (off == OFF_W'(i)) data_q[idx][hit_way][i*DATA_W +: DATA_W] <= WRITEDATA;
      end
    end
  end

endmodule

// File: tb/tb_assoc_data_cache.sv
// Directed bench for assoc_data_cache at default parameters against a fixed-latency block memory.
module tb_assoc_data_cache;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr;
  logic [7:0]  addr, wdata;
  logic [7:0]  rdata_o;
  logic        busy;
  logic        mem_rd, mem_wr;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assoc_data_cache dut (
    .CLK           (clk),
    .RESET         (rst_n),
    .READ          (rd),
    .WRITE         (wr),
    .ADDRESS       (addr),
    .WRITEDATA     (wdata),
    .READDATA      (rdata_o),
    .BUSYWAIT      (busy),
    .MEM_READ      (mem_rd),
    .MEM_WRITE     (mem_wr),
    .MEM_ADDRESS   (mem_addr),
    .MEM_WRITEDATA (mem_wdata),
    .MEM_READDATA  (mem_rdata),
    .MEM_BUSYWAIT  (mem_busy)
  );

  // Block memory: busy while a request is pending, completes LAT cycles after it is seen.
  logic [31:0] mem [64];
  logic        mem_ready = 1'b0;
  int          lat_cnt = 0;
  int          n_fetch = 0;
  int          n_wb = 0;
  logic [5:0]  last_fetch_addr = '0;
  logic [5:0]  last_wb_addr = '0;
  logic [31:0] last_wb_data = '0;

  assign mem_busy = (mem_rd | mem_wr) && (lat_cnt != LAT);

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= (i == 5) ? 32'hDDCCBBAA : {8'(i + 48), 8'(i + 32), 8'(i + 16), 8'(i)};
      mem_ready <= 1'b1;
    end
    if (mem_rd | mem_wr) begin
      if (lat_cnt == LAT) begin
        lat_cnt <= 0;
        if (mem_wr) begin
          mem[mem_addr] <= mem_wdata;
          n_wb          <= n_wb + 1;
          last_wb_addr  <= mem_addr;
          last_wb_data  <= mem_wdata;
        end else begin
          mem_rdata       <= mem[mem_addr];
          n_fetch         <= n_fetch + 1;
          last_fetch_addr <= mem_addr;
        end
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU access starting just after a rising edge; returns data and stall cycles.
  task automatic access(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] data, output int cycles);
    rd = r; wr = w; addr = a; wdata = d;
    cycles = 0;
    #1;
    while (busy === 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("stall_bound", 32'(busy), 32'd0);
    data = rdata_o;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] d;
  int         cyc;
  int         f0, w0;

  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = 8'h00; wdata = 8'h00;
    #1;
    check("rst_readdata", 32'(rdata_o), 32'd0);
    check("rst_busywait", 32'(busy), 32'd0);
    check("rst_mem_read", 32'(mem_rd), 32'd0);
    check("rst_mem_write", 32'(mem_wr), 32'd0);
    check("rst_mem_address", 32'(mem_addr), 32'd0);
    check("rst_mem_writedata", mem_wdata, 32'd0);
    do_reset();

    // Cold read miss, then a same-block hit.
    f0 = n_fetch;
    rd = 1'b1; addr = 8'h15;
    #1;
    check("cold_busy_same_cycle", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("cold_mem_read", 32'(mem_rd), 32'd1);
    check("cold_mem_address", 32'(mem_addr), 32'h05);
    check("cold_no_mem_write", 32'(mem_wr), 32'd0);
    access(1'b1, 1'b0, 8'h15, 8'h00, d, cyc);
    check("cold_readdata", 32'(d), 32'hBB);
    check("cold_fetch_count", 32'(n_fetch - f0), 32'd1);
    f0 = n_fetch;
    access(1'b1, 1'b0, 8'h14, 8'h00, d, cyc);
    check("hit_readdata", 32'(d), 32'hAA);
    check("hit_no_stall", 32'(cyc), 32'd0);
    check("hit_no_fetch", 32'(n_fetch - f0), 32'd0);

    // Two tags in set 1 fill both ways and then both hit.
    do_reset();
    access(1'b1, 1'b0, 8'h15, 8'h00, d, cyc);
    check("clean_miss_latency", 32'(cyc), 32'd5);
    access(1'b1, 1'b0, 8'h55, 8'h00, d, cyc);
    check("fill2_readdata", 32'(d), 32'h25);
    f0 = n_fetch; w0 = n_wb;
    access(1'b1, 1'b0, 8'h15, 8'h00, d, cyc);
    check("reread_way0", 32'(d), 32'hBB);
    check("reread_way0_stall", 32'(cyc), 32'd0);
    access(1'b1, 1'b0, 8'h55, 8'h00, d, cyc);
    check("reread_way1", 32'(d), 32'h25);
    check("reread_way1_stall", 32'(cyc), 32'd0);
    check("reread_traffic", 32'((n_fetch - f0) + (n_wb - w0)), 32'd0);

    // Dirty eviction: write back the modified block, then fetch the new one.
    do_reset();
    access(1'b1, 1'b1, 8'h15, 8'h3C, d, cyc);
    access(1'b1, 1'b0, 8'h55, 8'h00, d, cyc);
    f0 = n_fetch; w0 = n_wb;
    access(1'b1, 1'b0, 8'h95, 8'h00, d, cyc);
    check("dirty_wb_count", 32'(n_wb - w0), 32'd1);
    check("dirty_wb_addr", 32'(last_wb_addr), 32'h05);
    check("dirty_wb_data", last_wb_data, 32'hDDCC3CAA);
    check("dirty_fetch_addr", 32'(last_fetch_addr), 32'h25);
    check("dirty_readdata", 32'(d), 32'h35);
    check("dirty_miss_latency", 32'(cyc), 32'd8);
    access(1'b1, 1'b0, 8'h15, 8'h00, d, cyc);
    check("written_back_value", 32'(d), 32'h3C);

    // Same pattern without the store: clean eviction goes straight to fetch.
    do_reset();
    access(1'b1, 1'b0, 8'h15, 8'h00, d, cyc);
    access(1'b1, 1'b0, 8'h55, 8'h00, d, cyc);
    f0 = n_fetch; w0 = n_wb;
    access(1'b1, 1'b0, 8'h95, 8'h00, d, cyc);
    check("clean_no_wb", 32'(n_wb - w0), 32'd0);
    check("clean_fetch_addr", 32'(last_fetch_addr), 32'h25);
    check("clean_evict_latency", 32'(cyc), 32'd5);

    // Recency: touching 0x15 makes 0x55 the LRU victim.
    do_reset();
    access(1'b1, 1'b0, 8'h15, 8'h00, d, cyc);
    access(1'b1, 1'b0, 8'h55, 8'h00, d, cyc);
    access(1'b1, 1'b0, 8'h15, 8'h00, d, cyc);
    access(1'b1, 1'b0, 8'h95, 8'h00, d, cyc);
    access(1'b1, 1'b0, 8'h15, 8'h00, d, cyc);
    check("lru_mru_kept", 32'(cyc), 32'd0);
    access(1'b1, 1'b0, 8'h55, 8'h00, d, cyc);
    check("lru_victim_evicted", 32'(cyc), 32'd5);

    // Reset during FETCH drops the request and invalidates everything.
    do_reset();
    rd = 1'b1; addr = 8'h15;
    @(posedge clk); #1;
    check("pre_reset_mem_read", 32'(mem_rd), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_read", 32'(mem_rd), 32'd0);
    check("midrst_mem_address", 32'(mem_addr), 32'd0);
    check("midrst_busywait", 32'(busy), 32'd0);
    check("midrst_readdata", 32'(rdata_o), 32'd0);
    rd = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    f0 = n_fetch;
    access(1'b1, 1'b0, 8'h15, 8'h00, d, cyc);
    check("post_reset_miss", 32'(cyc), 32'd5);
    check("post_reset_fetch", 32'(n_fetch - f0), 32'd1);
    check("post_reset_data", 32'(d), 32'h3C);

    // READ and WRITE together behave as a store.
    access(1'b1, 1'b1, 8'h15, 8'h77, d, cyc);
    access(1'b1, 1'b0, 8'h15, 8'h00, d, cyc);
    check("rw_as_write", 32'(d), 32'h77);

    // No request: no stall and no memory traffic even for a missing address.
    f0 = n_fetch;
    addr = 8'hF0;
    #1;
    check("idle_no_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_fetch", 32'(n_fetch - f0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
